// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module   : multicycle_pkg
// Purpose  : State encoding, field codes and raw control vector for the
//            multicycle ARM sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
  } raw_ctrl_t;

  // Compares only set flags; they must never reach the regfile.
  function automatic logic is_nowrite(input logic [1:0] op, input logic [3:0] cmd);
    return (op == OP_DP) && ((cmd == CMD_CMP) || (cmd == CMD_CMN));
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module   : multicycle_ctrl_if
// Purpose  : Instruction-field inputs and control outputs between the
//            sequencer (master) and the datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       cond_ex;
  logic       mem_ready;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_op;

  modport master (
    input  op, funct, rd, cond_ex, mem_ready,
    output ir_write, pc_write, reg_write, mem_write,
           adr_src, alu_src_a, alu_src_b, result_src, alu_op
  );

  modport slave (
    output op, funct, rd, cond_ex, mem_ready,
    input  ir_write, pc_write, reg_write, mem_write,
           adr_src, alu_src_a, alu_src_b, result_src, alu_op
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
// ============================================================================
// Module   : multicycle_ctrl_decode
// Purpose  : Pure combinational state -> raw (ungated) control vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_decode
  import multicycle_pkg::*;
(
  input  state_t    i_state,
  output raw_ctrl_t o_raw
);

  always_comb begin
    o_raw = '0;
    case (i_state)
      S_FETCH: begin
        o_raw.alu_src_a  = 1'b1;
        o_raw.alu_src_b  = SRCB_FOUR;
        o_raw.result_src = RES_ALURES;
        o_raw.ir_write   = 1'b1;
        o_raw.nextpc     = 1'b1;
      end
      // Same PC+4 path again so an r15 operand reads PC+8.
      S_DECODE: begin
        o_raw.alu_src_a  = 1'b1;
        o_raw.alu_src_b  = SRCB_FOUR;
        o_raw.result_src = RES_ALURES;
      end
      S_MEMADR: o_raw.alu_src_b = SRCB_IMM;
      S_MEMRD: begin
        o_raw.result_src = RES_ALUOUT;
        o_raw.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        o_raw.result_src = RES_DATA;
        o_raw.regw       = 1'b1;
      end
      S_MEMWR: begin
        o_raw.result_src = RES_ALUOUT;
        o_raw.adr_src    = 1'b1;
        o_raw.memw       = 1'b1;
      end
      S_EXECR: begin
        o_raw.alu_src_b = SRCB_RD2;
        o_raw.alu_op    = 1'b1;
      end
      S_EXECI: begin
        o_raw.alu_src_b = SRCB_IMM;
        o_raw.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        o_raw.result_src = RES_ALUOUT;
        o_raw.regw       = 1'b1;
      end
      S_BRANCH: begin
        o_raw.alu_src_b  = SRCB_IMM;
        o_raw.result_src = RES_ALURES;
        o_raw.branch     = 1'b1;
      end
      default: o_raw = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle ARM main sequencer: state register, next-state logic
//            and cond_ex/rd gating. MEM_HANDSHAKE_EN stalls memory states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  multicycle_ctrl_if.master bus
);

  state_t    r_state;
  state_t    w_next;
  raw_ctrl_t w_raw;
  logic      w_mem_go;
  logic      w_regw;

`ifdef MEM_HANDSHAKE_EN
  assign w_mem_go = bus.mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = bus.mem_ready;
  assign w_mem_go           = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_mem_go) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DP:   w_next = bus.funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = bus.funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_mem_go) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (w_mem_go) w_next = S_FETCH;
      S_EXECR,
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB,
      S_BRANCH: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .i_state (r_state),
    .o_raw   (w_raw)
  );

  assign w_regw = w_raw.regw & bus.cond_ex & ~is_nowrite(bus.op, bus.funct[4:1]);

  // Enables are masked directly by reset_n; state is already FETCH during reset.
  assign bus.ir_write   = reset_n & w_raw.ir_write;
  assign bus.pc_write   = reset_n & (w_raw.nextpc | (w_raw.branch & bus.cond_ex) |
                                     (w_regw & (bus.rd == 4'hF)));
  assign bus.reg_write  = reset_n & w_regw;
  assign bus.mem_write  = reset_n & w_raw.memw & bus.cond_ex;
  assign bus.adr_src    = w_raw.adr_src;
  assign bus.alu_src_a  = w_raw.alu_src_a;
  assign bus.alu_src_b  = w_raw.alu_src_b;
  assign bus.result_src = w_raw.result_src;
  assign bus.alu_op     = w_raw.alu_op;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Directed per-cycle check of the multicycle sequencer outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  // {ir, pc, regw, memw, adr_src, src_a, src_b[1:0], result_src[1:0], alu_op}
  localparam logic [11:0] V_RST      = 12'b0000_0_1_10_10_0;
  localparam logic [11:0] V_FETCH    = 12'b1100_0_1_10_10_0;
  localparam logic [11:0] V_DECODE   = 12'b0000_0_1_10_10_0;
  localparam logic [11:0] V_MEMADR   = 12'b0000_0_0_01_00_0;
  localparam logic [11:0] V_MEMRD    = 12'b0000_1_0_00_00_0;
  localparam logic [11:0] V_MEMWB    = 12'b0010_0_0_00_01_0;
  localparam logic [11:0] V_MEMWB_PC = 12'b0110_0_0_00_01_0;
  localparam logic [11:0] V_MEMWR    = 12'b0001_1_0_00_00_0;
  localparam logic [11:0] V_MEMWR_NO = 12'b0000_1_0_00_00_0;
  localparam logic [11:0] V_EXECR    = 12'b0000_0_0_00_00_1;
  localparam logic [11:0] V_EXECI    = 12'b0000_0_0_01_00_1;
  localparam logic [11:0] V_ALUWB    = 12'b0010_0_0_00_00_0;
  localparam logic [11:0] V_ALUWB_PC = 12'b0110_0_0_00_00_0;
  localparam logic [11:0] V_ALUWB_NO = 12'b0000_0_0_00_00_0;
  localparam logic [11:0] V_BR       = 12'b0100_0_0_01_10_0;
  localparam logic [11:0] V_BR_NO    = 12'b0000_0_0_01_10_0;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [11:0] w_obs;
  assign w_obs = {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write,
                  bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_instr(input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic cond);
    bus.op      = op;
    bus.funct   = funct;
    bus.rd      = rd;
    bus.cond_ex = cond;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.mem_ready = 1'b1;
    set_instr(2'b00, 6'b001000, 4'd1, 1'b1);
    #3;
    n_checks++;
    if (w_obs !== V_RST) $display("FAIL reset_hold0: got %b want %b", w_obs, V_RST); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (w_obs !== V_RST) $display("FAIL reset_hold1: got %b want %b", w_obs, V_RST); else n_pass++;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== V_FETCH) $display("FAIL reset_release: got %b want %b", w_obs, V_FETCH); else n_pass++;
  endtask

  task automatic test_add();
    logic [11:0] e [4] = '{V_FETCH, V_DECODE, V_EXECR, V_ALUWB};
    set_instr(2'b00, 6'b001000, 4'd1, 1'b1);
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL add c%0d: got %b want %b", i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cmp();
    logic [11:0] e [4] = '{V_FETCH, V_DECODE, V_EXECR, V_ALUWB_NO};
    set_instr(2'b00, 6'b010101, 4'd0, 1'b1);
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL cmp c%0d: got %b want %b", i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cmn();
    logic [11:0] e [4] = '{V_FETCH, V_DECODE, V_EXECI, V_ALUWB_NO};
    set_instr(2'b00, 6'b110111, 4'd3, 1'b1);
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL cmn c%0d: got %b want %b", i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dp_imm_r15();
    logic [11:0] e [4] = '{V_FETCH, V_DECODE, V_EXECI, V_ALUWB_PC};
    set_instr(2'b00, 6'b101000, 4'hF, 1'b1);
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL dp_imm_r15 c%0d: got %b want %b", i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add_nocond();
    logic [11:0] e [4] = '{V_FETCH, V_DECODE, V_EXECR, V_ALUWB_NO};
    set_instr(2'b00, 6'b001000, 4'hF, 1'b0);
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL add_nocond c%0d: got %b want %b", i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ldr_r15();
    logic [11:0] e [5] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB_PC};
    set_instr(2'b01, 6'b011001, 4'hF, 1'b1);
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL ldr_r15 c%0d: got %b want %b", i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // funct[4:1] matches CMP, but op=01 so the load must still write back.
  task automatic test_ldr_cmpbits();
    logic [11:0] e [5] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
    set_instr(2'b01, 6'b010101, 4'd2, 1'b1);
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL ldr_cmpbits c%0d: got %b want %b", i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_str(input logic cond);
    logic [11:0] e [4];
    e = '{V_FETCH, V_DECODE, V_MEMADR, (cond ? V_MEMWR : V_MEMWR_NO)};
    set_instr(2'b01, 6'b011000, 4'd4, cond);
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL str_cond%0d c%0d: got %b want %b", cond, i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch(input logic cond);
    logic [11:0] e [3];
    e = '{V_FETCH, V_DECODE, (cond ? V_BR : V_BR_NO)};
    set_instr(2'b10, 6'b101000, 4'd0, cond);
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL branch_cond%0d c%0d: got %b want %b", cond, i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_undef();
    logic [11:0] e [2] = '{V_FETCH, V_DECODE};
    set_instr(2'b11, 6'b111111, 4'hF, 1'b1);
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL undef c%0d: got %b want %b", i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    set_instr(2'b00, 6'b001000, 4'd1, 1'b1);
    n_checks++;
    if (w_obs !== V_FETCH) $display("FAIL midrst_fetch: got %b want %b", w_obs, V_FETCH); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (w_obs !== V_DECODE) $display("FAIL midrst_decode: got %b want %b", w_obs, V_DECODE); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== V_RST) $display("FAIL midrst_async: got %b want %b", w_obs, V_RST); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (w_obs !== V_RST) $display("FAIL midrst_hold: got %b want %b", w_obs, V_RST); else n_pass++;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== V_FETCH) $display("FAIL midrst_release: got %b want %b", w_obs, V_FETCH); else n_pass++;
  endtask

`ifdef MEM_HANDSHAKE_EN
  task automatic test_handshake();
    set_instr(2'b01, 6'b011001, 4'd3, 1'b1);
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (w_obs !== V_FETCH) $display("FAIL hs_fetch c%0d: got %b want %b", k, w_obs, V_FETCH); else n_pass++;
      if (k == 1) bus.mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (w_obs !== V_DECODE) $display("FAIL hs_decode: got %b want %b", w_obs, V_DECODE); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (w_obs !== V_MEMADR) $display("FAIL hs_memadr: got %b want %b", w_obs, V_MEMADR); else n_pass++;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (w_obs !== V_MEMRD) $display("FAIL hs_memrd c%0d: got %b want %b", k, w_obs, V_MEMRD); else n_pass++;
      if (k == 3) bus.mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (w_obs !== V_MEMWB) $display("FAIL hs_memwb: got %b want %b", w_obs, V_MEMWB); else n_pass++;
    @(posedge clk); #1;
  endtask
`else
  task automatic test_ready_ignored();
    logic [11:0] e [5] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
    set_instr(2'b01, 6'b011001, 4'd3, 1'b1);
    bus.mem_ready = 1'b0;
    foreach (e[i]) begin
      n_checks++;
      if (w_obs !== e[i]) $display("FAIL ready_ignored c%0d: got %b want %b", i, w_obs, e[i]); else n_pass++;
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
  endtask
`endif

  task automatic test_final_fetch();
    set_instr(2'b00, 6'b001000, 4'd1, 1'b1);
    n_checks++;
    if (w_obs !== V_FETCH) $display("FAIL final_fetch: got %b want %b", w_obs, V_FETCH); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_add();
    test_cmp();
    test_cmn();
    test_dp_imm_r15();
    test_add_nocond();
    test_ldr_r15();
    test_ldr_cmpbits();
    test_str(1'b1);
    test_str(1'b0);
    test_branch(1'b0);
    test_branch(1'b1);
    test_undef();
    test_mid_reset();
`ifdef MEM_HANDSHAKE_EN
    test_handshake();
`else
    test_ready_ignored();
`endif
    test_final_fetch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
